// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, 16x oversampling, LSB-first de-framing and a
// single-byte holding register with framing/overrun flagging until the bus side acks.
module uart_rx #(
    parameter int unsigned freq_hz = 100000000,
    parameter int unsigned baud    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack
);

    localparam int unsigned DivRaw = freq_hz / (baud * 16);
    localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned PreW   = (Div > 1) ? $clog2(Div) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e            r_state, w_state_d;
    logic              r_sync1, r_sync2, r_prev;
    logic [PreW-1:0]   r_pre;
    logic [3:0]        r_s, w_s_d;
    logic [2:0]        r_bit, w_bit_d;
    logic [7:0]        r_shreg, w_shreg_d;
    logic [7:0]        r_data, w_data_d;
    logic              r_avail, w_avail_d;
    logic              r_error, w_error_d;
    logic              w_tick, w_sample, w_pre_clr;

    assign w_tick   = (r_pre == PreW'(Div - 1));
    assign w_sample = w_tick && (r_s == 4'd7);

    always_comb begin
        w_state_d = r_state;
        w_s_d     = r_s;
        w_bit_d   = r_bit;
        w_shreg_d = r_shreg;
        w_data_d  = r_data;
        w_avail_d = r_avail;
        w_error_d = r_error;
        w_pre_clr = 1'b0;
        if (rx_ack) begin
            w_avail_d = 1'b0;
            w_error_d = 1'b0;
        end
        unique case (r_state)
            StIdle: begin
                if (!r_sync2 && r_prev) begin
                    w_state_d = StStart;
                    w_s_d     = 4'd0;
                    w_pre_clr = 1'b1;
                end
            end
            StStart: begin
                // s wraps mod 16, so the next sample lands 16 ticks after this one
                if (w_tick) w_s_d = r_s + 4'd1;
                if (w_sample) begin
                    if (r_sync2) begin
                        w_state_d = StIdle;
                    end else begin
                        w_bit_d   = 3'd0;
                        w_state_d = StData;
                    end
                end
            end
            StData: begin
                if (w_tick) w_s_d = r_s + 4'd1;
                if (w_sample) begin
                    w_shreg_d = {r_sync2, r_shreg[7:1]};
                    if (r_bit == 3'd7) w_state_d = StStop;
                    else               w_bit_d   = r_bit + 3'd1;
                end
            end
            StStop: begin
                if (w_tick) w_s_d = r_s + 4'd1;
                if (w_sample) begin
                    w_data_d  = r_shreg;
                    w_avail_d = 1'b1;
                    // a coincident ack consumes the old byte, so only framing can flag
                    if (r_sync2) begin
                        w_error_d = r_avail && !rx_ack;
                        w_state_d = StIdle;
                    end else begin
                        w_error_d = 1'b1;
                        w_state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (r_sync2) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_pre   <= '0;
            r_s     <= 4'd0;
            r_bit   <= 3'd0;
            r_shreg <= 8'h00;
            r_data  <= 8'h00;
            r_avail <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_pre_clr || w_tick) r_pre <= '0;
            else                     r_pre <= r_pre + PreW'(1);
            r_s     <= w_s_d;
            r_bit   <= w_bit_d;
            r_shreg <= w_shreg_d;
            r_data  <= w_data_d;
            r_avail <= w_avail_d;
            r_error <= w_error_d;
        end
    end

    assign rx_data  = r_data;
    assign rx_avail = r_avail;
    assign rx_error = r_error;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases and random frames
// checked against a byte-level model of the holding register.
module tb_uart_rx;

    localparam int unsigned FreqHz = 1600000;
    localparam int unsigned Baud   = 100000;
    localparam int BitClk = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_avail, rx_error;

    int checks = 0;
    int failures = 0;
    int lat = 0;

    typedef struct packed {
        logic [7:0] din;
        logic       stop_ok;
        logic       ack;
        logic [7:0] e_data;
        logic       e_avail;
        logic       e_err;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    uart_rx #(.freq_hz(FreqHz), .baud(Baud)) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic a,
                             input logic e);
        check({name, ".data"}, rx_data, d);
        check({name, ".avail"}, {7'd0, rx_avail}, {7'd0, a});
        check({name, ".error"}, {7'd0, rx_error}, {7'd0, e});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        wait_clk(BitClk);
    endtask

    // A bad stop bit keeps the line low for three further bit times.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            repeat (4) drive_bit(1'b0);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] m_data;
        logic       m_avail, m_err;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[7] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};

        wait_clk(3);
        check_out("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        wait_clk(2);

        // First frame with latency measured from the start-bit drive
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!rx_avail && lat < 400) begin
                    wait_clk(1);
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 150 || lat > 160) begin
            failures++;
            $display("FAIL latency: got %0d clk expected 150..160", lat);
            lat = 155;
        end
        check_out("first_a5", 8'hA5, 1'b1, 1'b0);
        pulse_ack();
        check_out("ack_clear", 8'hA5, 1'b0, 1'b0);
        wait_clk(32);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].ack) pulse_ack();
            send_frame(vecs[i].din, vecs[i].stop_ok);
            wait_clk(32);
            check_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_avail, vecs[i].e_err);
        end

        // Short low glitch must be rejected, then a frame right behind it must be clean
        pulse_ack();
        uart_rxd = 1'b0;
        wait_clk(4);
        uart_rxd = 1'b1;
        wait_clk(200);
        check("glitch.avail", {7'd0, rx_avail}, 8'd0);
        uart_rxd = 1'b0;
        wait_clk(4);
        uart_rxd = 1'b1;
        wait_clk(12);
        send_frame(8'h96, 1'b1);
        wait_clk(32);
        check_out("after_glitch", 8'h96, 1'b1, 1'b0);

        // Back-to-back overrun, then ack clears both flags
        pulse_ack();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(8);
        check_out("overrun", 8'h22, 1'b1, 1'b1);
        pulse_ack();
        check_out("overrun_ack", 8'h22, 1'b0, 1'b0);
        wait_clk(16);

        // Ack landing on the completion clock: the new byte wins, no overrun
        send_frame(8'h5A, 1'b1);
        wait_clk(32);
        check_out("held_5a", 8'h5A, 1'b1, 1'b0);
        fork
            send_frame(8'h81, 1'b1);
            begin
                wait_clk(lat - 1);
                rx_ack = 1'b1;
                wait_clk(1);
                rx_ack = 1'b0;
            end
        join
        wait_clk(8);
        check_out("ack_on_done", 8'h81, 1'b1, 1'b0);

        // Reset pulse during data bit 3 of 0xF0
        uart_rxd = 1'b0;
        wait_clk(4 * BitClk + 8);
        reset = 1'b0;
        uart_rxd = 1'b1;
        wait_clk(1);
        check_out("mid_reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        wait_clk(200);
        check("post_reset.avail", {7'd0, rx_avail}, 8'd0);
        send_frame(8'h0F, 1'b1);
        wait_clk(32);
        check_out("after_reset", 8'h0F, 1'b1, 1'b0);

        // Random frames against the holding-register model
        pulse_ack();
        m_data  = 8'h0F;
        m_avail = 1'b0;
        m_err   = 1'b0;
        wait_clk(16);
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            logic       stop_ok, ack;
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            ack     = 1'($urandom_range(0, 1));
            if (ack) begin
                pulse_ack();
                m_avail = 1'b0;
                m_err   = 1'b0;
            end
            send_frame(b, stop_ok);
            m_err   = stop_ok ? m_avail : 1'b1;
            m_avail = 1'b1;
            m_data  = b;
            wait_clk($urandom_range(16, 40));
            check_out($sformatf("rand%0d", n), m_data, m_avail, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
